// File: rtl/l2_feeder.sv
// Layer-2 feeder: walks the layer-1 feature RAM and streams TAPS data pairs per output pixel.
// Optional build macro L2_FEED_PAD_EN zero-pads reads at or beyond SRC_LEN.
module l2_feeder #(
    parameter int TAPS    = 10,
    parameter int NUM_PIX = 120,
    parameter int STRIDE  = 1,
    parameter int SRC_AW  = 8,
    parameter int SRC_LEN = 129
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                tx_done,
    input  logic                bsy_in,
    output logic [SRC_AW-1:0]   src_addr,
    output logic                src_rd,
    input  logic signed [17:0]  src_din_0,
    input  logic signed [17:0]  src_din_1,
    output logic                strt,
    output logic signed [17:0]  din_0,
    output logic signed [17:0]  din_1,
    output logic                done
);
    // state  | meaning
    // IDLE   | waiting for go
    // PRIME  | issue tap 0 read once the consumer is free
    // STRT   | strt pulse, tap 1 read
    // STREAM | remaining tap reads, din follows one cycle behind
    // WAIT   | hold off until the consumer drains
    // DONE   | frame complete, done held high

    localparam int TW = $clog2(TAPS + 2);
    localparam int PW = $clog2(NUM_PIX + 1);

`ifdef L2_FEED_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_STRT, S_STREAM, S_WAIT, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     tap_cnt, tap_nxt;
    logic [PW-1:0]     pix_cnt, pix_nxt;
    logic [SRC_AW-1:0] base, base_nxt;
    logic [SRC_AW-1:0] rd_addr;
    logic              issue;
    logic              in_range;
    logic              rd_q;

    assign rd_addr  = base + SRC_AW'(tap_cnt);
    assign in_range = !PAD_ON || (32'(rd_addr) < 32'(SRC_LEN));

    assign strt     = (state == S_STRT);
    assign done     = (state == S_DONE);
    assign src_rd   = issue && in_range;
    assign src_addr = issue ? rd_addr : '0;

    always_comb begin
        state_nxt = state;
        tap_nxt   = tap_cnt;
        pix_nxt   = pix_cnt;
        base_nxt  = base;
        issue     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    pix_nxt   = '0;
                    base_nxt  = '0;
                    tap_nxt   = '0;
                    state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                if (!bsy_in) begin
                    issue     = 1'b1;
                    tap_nxt   = TW'(1);
                    state_nxt = S_STRT;
                end
            end
            S_STRT: begin
                issue     = 1'b1;
                tap_nxt   = tap_cnt + TW'(1);
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (tap_cnt < TW'(TAPS)) begin
                    issue   = 1'b1;
                    tap_nxt = tap_cnt + TW'(1);
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // First WAIT cycle still shows the last tap; busy is only trusted from the next one.
                if (tap_cnt == TW'(TAPS)) begin
                    tap_nxt = TW'(TAPS + 1);
                end else if (!bsy_in) begin
                    if (pix_cnt == PW'(NUM_PIX - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        pix_nxt   = pix_cnt + PW'(1);
                        base_nxt  = base + SRC_AW'(STRIDE);
                        tap_nxt   = '0;
                        state_nxt = S_PRIME;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tap_cnt <= '0;
            pix_cnt <= '0;
            base    <= '0;
            rd_q    <= 1'b0;
            din_0   <= '0;
            din_1   <= '0;
        end else if (tx_done) begin
            state   <= S_IDLE;
            tap_cnt <= '0;
            pix_cnt <= '0;
            base    <= '0;
            rd_q    <= 1'b0;
            din_0   <= '0;
            din_1   <= '0;
        end else begin
            state   <= state_nxt;
            tap_cnt <= tap_nxt;
            pix_cnt <= pix_nxt;
            base    <= base_nxt;
            rd_q    <= src_rd;
            // Zero whenever no read landed, so the consumer can accumulate idle cycles freely.
            din_0   <= rd_q ? src_din_0 : '0;
            din_1   <= rd_q ? src_din_1 : '0;
        end
    end

endmodule
